// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
// FSM state encodings are plain constants so legacy code can compare against them.
package mem_resp_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t RESP = 2'd2;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WAIT_CNT_W = 4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/sram_be.sv
// Single-port synchronous RAM with per-byte write enables and registered read data.
// Contents are deliberately not reset.
module sram_be
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   // Read data only updates on an enabled load, so it holds across the response phase.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one word access, waits WAIT_CYCLES, commits to the
// on-chip RAM and returns read data or an error over a valid/ready response channel.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   state_t                  state;
   logic [WAIT_CNT_W-1:0]   cnt;
   logic                    we_q;
   logic                    err_q;
   logic [ADDR_W-1:0]       widx_q;
   logic [31:0]             wdata_q;
   logic [WORD_BYTES-1:0]   be_q;
   logic                    req_err;
   logic                    commit;
   logic [31:0]             rd_word;

   assign req_err = is_misaligned(req_addr) || ((req_addr >> (ADDR_W + 2)) != 32'd0);

   // Gating with rst keeps a commit that lands on a reset edge from touching the RAM.
   assign commit = (state == WAIT) && (cnt == '0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  err_q   <= req_err;
                  widx_q  <= req_addr[ADDR_W+1:2];
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  cnt     <= WAIT_CNT_W'(WAIT_CYCLES);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) state <= RESP;
               else           cnt   <= cnt - 1'b1;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sram_be #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (commit && !err_q),
      .we    (we_q),
      .be    (be_q),
      .addr  (widx_q),
      .wdata (wdata_q),
      .rdata (rd_word)
   );

   // Response fields are qualified by state, so leaving RESP clears them.
   assign req_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err_q;
   assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? rd_word : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; three instances cover WAIT_CYCLES of 2, 3 and 0,
// selected through sel and sharing clock, reset and request stimulus.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_ready;
   logic [1:0]  sel;

   logic [2:0]  req_ready_a;
   logic [2:0]  rsp_valid_a;
   logic [2:0]  rsp_err_a;
   logic [31:0] rsp_rdata_a [3];

   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign req_ready = req_ready_a[sel];
   assign rsp_valid = rsp_valid_a[sel];
   assign rsp_err   = rsp_err_a[sel];
   assign rsp_rdata = rsp_rdata_a[sel];

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel == 2'd0), .req_ready(req_ready_a[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready && sel == 2'd0),
      .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
   );

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel == 2'd1), .req_ready(req_ready_a[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready && sel == 2'd1),
      .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
   );

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel == 2'd2), .req_ready(req_ready_a[2]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready && sel == 2'd2),
      .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_a[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full access with rsp_ready high; lat counts edges from acceptance to rsp_valid.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata,
                         output logic err, output int lat);
      int t;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      t = 0;
      while (!req_ready && t < 50) begin
         tick();
         t++;
      end
      if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
      tick();
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      rdata = rsp_rdata;
      err   = rsp_err;
      tick();
      check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
      check("post_hs_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          t;

      sel = 2'd0;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_be = '0;
      rsp_ready = 1'b0;
      repeat (3) tick();

      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      rst = 1'b0;
      tick();
      check("rel_req_ready", {31'd0, req_ready}, 32'd1);

      // Full store, then load back, WAIT_CYCLES=2
      access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      check("st10_lat",   lat, 32'd3);
      check("st10_err",   {31'd0, er}, 32'd0);
      check("st10_rdata", rd, 32'd0);
      access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check("ld10_lat",   lat, 32'd3);
      check("ld10_rdata", rd, 32'hDEADBEEF);
      check("ld10_err",   {31'd0, er}, 32'd0);

      // Partial store with be=0101
      access(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
      access(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat);
      access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      check("partial_rdata", rd, 32'h11BB33DD);

      // Misaligned load
      access(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
      check("misal_err",   {31'd0, er}, 32'd1);
      check("misal_rdata", rd, 32'd0);

      // Out-of-range store aliases word 0 in its low bits but must not write
      access(1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
      access(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er, lat);
      check("oor_err",   {31'd0, er}, 32'd1);
      check("oor_rdata", rd, 32'd0);
      access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      check("oor_word0", rd, 32'h01020304);

      // Store with no byte enables
      access(1'b1, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check("be0_err", {31'd0, er}, 32'd0);
      access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      check("be0_word", rd, 32'hDEADBEEF);

      // Backpressure with a second request pending
      req_we = 1'b0;
      req_addr = 32'h20;
      req_be = 4'h0;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      req_addr = 32'h10;
      t = 0;
      while (!rsp_valid && t < 50) begin
         tick();
         t++;
      end
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         check("bp_rdata", rsp_rdata, 32'h11BB33DD);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
      check("bp_hs_ready", {31'd0, req_ready}, 32'd1);
      check("bp_hs_rdata", rsp_rdata, 32'd0);
      tick();
      check("bp_accepted", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      t = 0;
      while (!rsp_valid && t < 50) begin
         tick();
         t++;
      end
      check("bp_next_rdata", rsp_rdata, 32'hDEADBEEF);
      tick();

      // Reset mid-operation on the WAIT_CYCLES=3 instance
      sel = 2'd1;
      access(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
      check("w3_lat", lat, 32'd4);
      req_we = 1'b1;
      req_addr = 32'h30;
      req_wdata = 32'h55555555;
      req_be = 4'hF;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("w3_accepted", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      tick();
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      repeat (5) begin
         tick();
         check("mid_rst_idle_valid", {31'd0, rsp_valid}, 32'd0);
      end
      check("mid_rst_idle_ready", {31'd0, req_ready}, 32'd1);
      access(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
      check("mid_rst_word", rd, 32'h0);

      // RAM contents survive reset
      sel = 2'd0;
      access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check("survive_rst", rd, 32'hDEADBEEF);

      // Zero wait states
      sel = 2'd2;
      access(1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, lat);
      check("w0_st_lat", lat, 32'd1);
      access(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
      check("w0_ld_lat",   lat, 32'd1);
      check("w0_ld_rdata", rd, 32'h12345678);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
